mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit (MDU) in the EX stage, alongside the ALU.
- Takes the same two 32-bit operands the ALU does. Results are written to private HI/LO registers after a fixed latency, not returned in the same cycle.
- Exposes `busy` so the hazard unit can stall mfhi/mflo/mult/div behind an in-flight operation.
- Also services mthi/mtlo register writes.

---
 rtl/mult_div_unit_pkg.sv | 25 ++
 rtl/mult_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared operation codes, default latencies and FSM state type for the
// multi-cycle multiply/divide unit.
package mult_div_unit_pkg;

    localparam logic [3:0] MDOP_NONE  = 4'd0;
    localparam logic [3:0] MDOP_MULT  = 4'd1;
    localparam logic [3:0] MDOP_MULTU = 4'd2;
    localparam logic [3:0] MDOP_DIV   = 4'd3;
    localparam logic [3:0] MDOP_DIVU  = 4'd4;
    localparam logic [3:0] MDOP_MTHI  = 4'd5;
    localparam logic [3:0] MDOP_MTLO  = 4'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: result is computed at issue, held as pending,
// and committed to HI/LO after a fixed busy window.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic [31:0]        pend_hi_r;
    logic [31:0]        pend_lo_r;
    logic               pend_we_r;

    logic [63:0]        ext_a_s;
    logic [63:0]        ext_b_s;
    logic [63:0]        prod_s;
    logic [31:0]        num_s;
    logic [31:0]        den_s;
    logic [31:0]        den_safe_s;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        res_hi_s;
    logic [31:0]        res_lo_s;
    logic               res_we_s;
    logic               is_run_s;
    logic [CNT_W-1:0]   run_len_s;

    // Shared 64-bit multiplier; sign extension selects signed vs unsigned product.
    always_comb begin
        if (mdop == MDOP_MULT) begin
            ext_a_s = {{32{A[31]}}, A};
            ext_b_s = {{32{B[31]}}, B};
        end else begin
            ext_a_s = {32'd0, A};
            ext_b_s = {32'd0, B};
        end
    end

    assign prod_s = ext_a_s * ext_b_s;

    // Signed division runs on magnitudes; signs are restored afterwards.
    always_comb begin
        if (mdop == MDOP_DIV) begin
            num_s = abs32(A);
            den_s = abs32(B);
        end else begin
            num_s = A;
            den_s = B;
        end
    end

    // The divisor is forced non-zero so the divider never sees 0; the
    // divide-by-zero result is discarded through res_we_s anyway.
    assign den_safe_s = (den_s == 32'd0) ? 32'd1 : den_s;
    assign quo_s      = num_s / den_safe_s;
    assign rem_s      = num_s % den_safe_s;

    // Result, write-enable and latency selection for the issued operation.
    always_comb begin
        res_hi_s  = 32'd0;
        res_lo_s  = 32'd0;
        res_we_s  = 1'b0;
        is_run_s  = 1'b0;
        run_len_s = '0;
        case (mdop)
            MDOP_MULT, MDOP_MULTU: begin
                res_hi_s  = prod_s[63:32];
                res_lo_s  = prod_s[31:0];
                res_we_s  = 1'b1;
                is_run_s  = 1'b1;
                run_len_s = CNT_W'(MULT_CYCLES);
            end
            MDOP_DIV: begin
                res_lo_s  = (A[31] ^ B[31]) ? (32'd0 - quo_s) : quo_s;
                res_hi_s  = A[31] ? (32'd0 - rem_s) : rem_s;
                res_we_s  = (B != 32'd0);
                is_run_s  = 1'b1;
                run_len_s = CNT_W'(DIV_CYCLES);
            end
            MDOP_DIVU: begin
                res_lo_s  = quo_s;
                res_hi_s  = rem_s;
                res_we_s  = (B != 32'd0);
                is_run_s  = 1'b1;
                run_len_s = CNT_W'(DIV_CYCLES);
            end
            MDOP_NONE: begin
                is_run_s = 1'b0;
            end
            default: begin
                is_run_s = 1'b0;
            end
        endcase
    end

    // Issue/commit FSM; also performs single-cycle mthi/mtlo writes in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_we_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && is_run_s) begin
                        pend_hi_r <= res_hi_s;
                        pend_lo_r <= res_lo_s;
                        pend_we_r <= res_we_s;
                        cnt_r     <= run_len_s;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RUN;
                    end else if (start && (mdop == MDOP_MTHI)) begin
                        hi_r <= A;
                    end else if (start && (mdop == MDOP_MTLO)) begin
                        lo_r <= A;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        if (pend_we_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed vectors.
module tb_mult_div_unit;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors;
    int checks;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one op before the next rising edge; returns 1ns after that edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = OP_NONE;
    endtask

    // Called 1ns after the issue edge; checks the full busy window and commit.
    task automatic run_check(input string tag, input int n,
                             input logic [31:0] old_hi, input logic [31:0] old_lo,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_hold_hi"}, hi, old_hi);
            chk({tag, "_hold_lo"}, lo, old_lo);
            @(posedge clk);
            #1;
        end
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;
        mdop   = OP_NONE;
        A      = 32'd0;
        B      = 32'd0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
        run_check("mult", 5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        run_check("multu", 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        run_check("div", 10, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(OP_DIVU, 32'd7, 32'd2);
        run_check("divu", 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3);

        issue(OP_MTHI, 32'h00001234, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h00001234);
        chk("mthi_lo", lo, 32'd3);
        issue(OP_MTLO, 32'h00005678, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_hi", hi, 32'h00001234);
        chk("mtlo_lo", lo, 32'h00005678);

        issue(OP_NONE, 32'hAAAAAAAA, 32'd1);
        chk("none_busy", {31'd0, busy}, 32'd0);
        chk("none_hi", hi, 32'h00001234);
        issue(4'hF, 32'hBBBBBBBB, 32'd1);
        chk("unk_busy", {31'd0, busy}, 32'd0);
        chk("unk_lo", lo, 32'h00005678);

        issue(OP_DIV, 32'd5, 32'd0);
        run_check("div0", 10, 32'h00001234, 32'h00005678, 32'h00001234, 32'h00005678);
        issue(OP_DIVU, 32'd9, 32'd0);
        run_check("divu0", 10, 32'h00001234, 32'h00005678, 32'h00001234, 32'h00005678);

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_check("div_ovf", 10, 32'h00001234, 32'h00005678, 32'd0, 32'h80000000);

        // mtlo on busy cycle 2 must be ignored; mult completes normally.
        issue(OP_MULT, 32'd3, 32'd4);
        chk("ign_busy1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b1;
        mdop  = OP_MTLO;
        A     = 32'h0000DEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = OP_NONE;
        chk("ign_lo_hold", lo, 32'h80000000);
        run_check("ign", 4, 32'd0, 32'h80000000, 32'd0, 32'd12);

        // Issue on the cycle busy drops: accepted, new 5-cycle window.
        issue(OP_MULT, 32'h00010000, 32'h00010000);
        run_check("b2b", 5, 32'd0, 32'd12, 32'd1, 32'd0);

        // Asynchronous reset mid-divide aborts with no later commit.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        chk("abort_late_busy", {31'd0, busy}, 32'd0);
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        run_check("mult_neg", 5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
